// File: rtl/delay_meter_pkg.sv
// delay_meter shared types
// Channel state and index-width helper.
package delay_meter_pkg;

    typedef enum logic {
        CH_IDLE  = 1'b0,
        CH_ARMED = 1'b1
    } ch_state_e;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/delay_meter_ch.sv
// delay_meter channel
// Sync, edge detect, start/end FSM, counter, pending slot.
module delay_meter_ch
    import delay_meter_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int TIMEOUT     = 2**(WIDTH-1),
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             t_start,
    input  logic             t_end,
    input  logic             clear,
    input  logic             take,
    output logic             pend,
    output logic [WIDTH-1:0] slot_delay,
    output logic             slot_timeout,
    output logic             overrun
);

    typedef struct packed {
        logic [WIDTH-1:0] delay;
        logic             timeout;
    } res_t;

    localparam int MSB = SYNC_STAGES - 1;
    localparam logic [WIDTH-1:0] TO_VAL = WIDTH'(TIMEOUT);

    logic [MSB:0]     start_sync;
    logic [MSB:0]     end_sync;
    logic             start_hist;
    logic             end_hist;
    logic             start_edge;
    logic             end_edge;
    ch_state_e        state;
    logic [WIDTH-1:0] count;
    logic             cap;
    res_t             cap_res;
    res_t             slot;

    // synchronisers and edge history, preset high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_sync <= '1;
            end_sync   <= '1;
            start_hist <= 1'b1;
            end_hist   <= 1'b1;
        end else begin
            start_sync <= {start_sync[MSB-1:0], t_start};
            end_sync   <= {end_sync[MSB-1:0], t_end};
            start_hist <= start_sync[MSB];
            end_hist   <= end_sync[MSB];
        end
    end

    assign start_edge = start_sync[MSB] & ~start_hist;
    assign end_edge   = end_sync[MSB] & ~end_hist;

    // capture on end edge, or on timeout unless a restart wins
    always_comb begin
        cap             = 1'b0;
        cap_res.delay   = count;
        cap_res.timeout = 1'b0;
        if (state == CH_ARMED && !clear) begin
            if (end_edge) begin
                cap = 1'b1;
            end else if (!start_edge && count == TO_VAL) begin
                cap             = 1'b1;
                cap_res.timeout = 1'b1;
            end
        end
    end

    // channel FSM and elapsed counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CH_IDLE;
            count <= '0;
        end else if (clear) begin
            state <= CH_IDLE;
            count <= '0;
        end else if (start_edge) begin
            state <= CH_ARMED;
            count <= WIDTH'(1);
        end else if (state == CH_ARMED) begin
            if (cap) begin
                state <= CH_IDLE;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    // one-deep result slot with sticky overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend    <= 1'b0;
            slot    <= '0;
            overrun <= 1'b0;
        end else if (clear) begin
            pend    <= 1'b0;
            overrun <= 1'b0;
        end else if (cap) begin
            slot <= cap_res;
            pend <= 1'b1;
            if (pend && !take) begin
                overrun <= 1'b1;
            end
        end else if (take) begin
            pend <= 1'b0;
        end
    end

    assign slot_delay   = slot.delay;
    assign slot_timeout = slot.timeout;

endmodule

// File: rtl/delay_meter.sv
// delay_meter top
// N_CH channels, round-robin arbiter, output register.
module delay_meter
    import delay_meter_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int WIDTH       = 16,
    parameter int TIMEOUT     = 2**(WIDTH-1),
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH-1:0]         t_start,
    input  logic [N_CH-1:0]         t_end,
    input  logic                    clear,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [ch_w(N_CH)-1:0]   res_ch,
    output logic [WIDTH-1:0]        res_delay,
    output logic                    res_timeout,
    output logic [N_CH-1:0]         overrun
);

    localparam int CW = ch_w(N_CH);
    localparam logic [CW-1:0] LAST = CW'(N_CH - 1);

    logic [N_CH-1:0]  pend;
    logic [N_CH-1:0]  take;
    logic [N_CH-1:0]  ch_ovr;
    logic [N_CH-1:0]  slot_to;
    logic [WIDTH-1:0] slot_delay [N_CH];
    logic [CW-1:0]    ptr;
    logic [CW-1:0]    grant;
    logic             any;
    logic             load;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        delay_meter_ch #(
            .WIDTH       (WIDTH),
            .TIMEOUT     (TIMEOUT),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_ch (
            .clk          (clk),
            .rst_n        (rst_n),
            .t_start      (t_start[i]),
            .t_end        (t_end[i]),
            .clear        (clear),
            .take         (take[i]),
            .pend         (pend[i]),
            .slot_delay   (slot_delay[i]),
            .slot_timeout (slot_to[i]),
            .overrun      (ch_ovr[i])
        );
    end

    // first pending channel at or after ptr
    always_comb begin
        int            idx;
        logic [CW-1:0] sel;
        grant = '0;
        any   = 1'b0;
        idx   = 0;
        sel   = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N_CH) begin
                idx = idx - N_CH;
            end
            sel = CW'(idx);
            if (pend[sel]) begin
                grant = sel;
                any   = 1'b1;
            end
        end
    end

    assign load = any & ~clear & (~res_valid | res_ready);

    // hand the granted slot to the output register
    always_comb begin
        take = '0;
        if (load) begin
            take[grant] = 1'b1;
        end
    end

    // output register and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid   <= 1'b0;
            res_ch      <= '0;
            res_delay   <= '0;
            res_timeout <= 1'b0;
            ptr         <= '0;
        end else if (load) begin
            res_valid   <= 1'b1;
            res_ch      <= grant;
            res_delay   <= slot_delay[grant];
            res_timeout <= slot_to[grant];
            ptr         <= (grant == LAST) ? '0 : grant + 1'b1;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

    assign overrun = ch_ovr;

endmodule

// File: tb/tb_delay_meter.sv
// delay_meter bench
// Directed scenarios plus random traffic against an event-time model.
module tb_delay_meter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int TO = 128;
    localparam int SS = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] t_start = '0;
    logic [N-1:0] t_end = '0;
    logic         clear = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [1:0]   res_ch;
    logic [W-1:0] res_delay;
    logic         res_timeout;
    logic [N-1:0] overrun;

    int n_run = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int          ch;
        logic [16:0] val;
    } exp_t;
    exp_t exp_q[$];

    bit st_lvl[N];
    bit en_lvl[N];
    int st_cnt[N];
    int en_cnt[N];
    bit armed[N];
    int s_cyc[N];
    int cyc;

    delay_meter #(
        .N_CH        (N),
        .WIDTH       (W),
        .TIMEOUT     (TO),
        .SYNC_STAGES (SS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .t_start     (t_start),
        .t_end       (t_end),
        .clear       (clear),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_ch      (res_ch),
        .res_delay   (res_delay),
        .res_timeout (res_timeout),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse(input logic [N-1:0] s, input logic [N-1:0] e);
        t_start = t_start | s;
        t_end   = t_end | e;
        tick();
        tick();
        t_start = t_start & ~s;
        t_end   = t_end & ~e;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        t_start = '0;
        t_end   = '0;
        clear   = 1'b0;
        gap(3);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_valid(input string tag, input int lim);
        int n = 0;
        while (!res_valid && n < lim) begin
            tick();
            n++;
        end
        check({tag, " valid"}, 32'(res_valid), 32'd1);
    endtask

    task automatic chk_res(input string tag, input int ch,
                           input int dly, input int to);
        check({tag, " ch"}, 32'(res_ch), 32'(ch));
        check({tag, " delay"}, 32'(res_delay), 32'(dly));
        check({tag, " timeout"}, 32'(res_timeout), 32'(to));
    endtask

    task automatic chk_reset(input string tag);
        check({tag, " valid"}, 32'(res_valid), 32'd0);
        check({tag, " ch"}, 32'(res_ch), 32'd0);
        check({tag, " delay"}, 32'(res_delay), 32'd0);
        check({tag, " timeout"}, 32'(res_timeout), 32'd0);
        check({tag, " overrun"}, 32'(overrun), 32'd0);
    endtask

    // Reference: results are a function of pin rise times only.
    task automatic model_step(input int ch, input bit st, input bit en);
        exp_t e;
        e.ch = ch;
        if (armed[ch] && en) begin
            e.val = {1'b0, 16'(cyc - s_cyc[ch])};
            exp_q.push_back(e);
            armed[ch] = 1'b0;
        end else if (armed[ch] && !st && cyc - s_cyc[ch] == TO) begin
            e.val = {1'b1, 16'(TO)};
            exp_q.push_back(e);
            armed[ch] = 1'b0;
        end
        if (st) begin
            armed[ch] = 1'b1;
            s_cyc[ch] = cyc;
        end
    endtask

    task automatic rand_phase(input int ncyc, input bit gen);
        for (int c = 0; c < ncyc; c++) begin
            for (int ch = 0; ch < N; ch++) begin
                bit sr;
                bit er;
                sr = 1'b0;
                er = 1'b0;
                if (st_lvl[ch] && st_cnt[ch] >= 2) begin
                    st_lvl[ch] = 1'b0;
                    st_cnt[ch] = 1;
                end else if (!st_lvl[ch] && st_cnt[ch] >= 2 && gen &&
                             $urandom_range(0, 11) == 0) begin
                    st_lvl[ch] = 1'b1;
                    st_cnt[ch] = 1;
                    sr = 1'b1;
                end else begin
                    st_cnt[ch]++;
                end
                if (en_lvl[ch] && en_cnt[ch] >= 2) begin
                    en_lvl[ch] = 1'b0;
                    en_cnt[ch] = 1;
                end else if (!en_lvl[ch] && en_cnt[ch] >= 2 && gen &&
                             $urandom_range(0, 39) == 0) begin
                    en_lvl[ch] = 1'b1;
                    en_cnt[ch] = 1;
                    er = 1'b1;
                end else begin
                    en_cnt[ch]++;
                end
                model_step(ch, sr, er);
                t_start[ch] = st_lvl[ch];
                t_end[ch]   = en_lvl[ch];
            end
            tick();
            cyc++;
        end
    endtask

    // scoreboard: each transfer must match the oldest result of its channel
    always @(negedge clk) begin
        if (mon_en && res_valid && res_ready) begin : mon
            int          idx;
            logic [31:0] want;
            idx  = -1;
            want = '1;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (idx < 0 && exp_q[i].ch == int'(res_ch)) begin
                    idx = i;
                end
            end
            if (idx >= 0) begin
                want = {13'b0, 2'(exp_q[idx].ch), exp_q[idx].val};
                exp_q.delete(idx);
            end
            check("rand res", {13'b0, res_ch, res_timeout, res_delay},
                  want);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        int bad;
        logic [1:0]   s_ch;
        logic [W-1:0] s_dly;

        gap(2);
        chk_reset("reset");
        rst_n = 1'b1;
        tick();

        // ch0 plain measurement of 100
        res_ready = 1'b1;
        pulse(4'b0001, 4'b0000);
        gap(98);
        pulse(4'b0000, 4'b0001);
        wait_valid("t1", 40);
        chk_res("t1", 0, 100, 0);
        tick();

        // ch2 timeout, then a lone end is ignored
        pulse(4'b0100, 4'b0000);
        wait_valid("t2", TO + 40);
        chk_res("t2", 2, TO, 1);
        tick();
        pulse(4'b0000, 4'b0100);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (res_valid) cnt++;
            tick();
        end
        check("t2 lone end", 32'(cnt), 32'd0);

        // all channels end together under a stall
        do_reset();
        res_ready = 1'b0;
        pulse(4'b1111, 4'b0000);
        gap(8);
        pulse(4'b0000, 4'b1111);
        wait_valid("t3", 20);
        s_ch  = res_ch;
        s_dly = res_delay;
        check("t3 first ch", 32'(s_ch), 32'd0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!res_valid || res_ch != s_ch || res_delay != s_dly) bad++;
        end
        check("t3 stable", 32'(bad), 32'd0);
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3 v%0d", i), 32'(res_valid), 32'd1);
            chk_res($sformatf("t3 r%0d", i), i, 10, 0);
            tick();
        end
        check("t3 drained", 32'(res_valid), 32'd0);
        check("t3 overrun", 32'(overrun), 32'd0);

        // ch1 overwritten while output is held
        res_ready = 1'b0;
        pulse(4'b0001, 4'b0000);
        gap(1);
        pulse(4'b0000, 4'b0001);
        wait_valid("t4", 20);
        pulse(4'b0010, 4'b0000);
        gap(3);
        pulse(4'b0000, 4'b0010);
        gap(4);
        pulse(4'b0010, 4'b0000);
        gap(5);
        pulse(4'b0000, 4'b0010);
        gap(10);
        check("t4 overrun", 32'(overrun), 32'h2);
        res_ready = 1'b1;
        chk_res("t4 a", 0, 3, 0);
        tick();
        check("t4 b valid", 32'(res_valid), 32'd1);
        chk_res("t4 b", 1, 7, 0);
        tick();
        check("t4 empty", 32'(res_valid), 32'd0);
        check("t4 sticky", 32'(overrun), 32'h2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t4 cleared", 32'(overrun), 32'd0);

        // ch0 restart, then start+end in one cycle
        pulse(4'b0001, 4'b0000);
        gap(18);
        pulse(4'b0001, 4'b0000);
        gap(28);
        pulse(4'b0000, 4'b0001);
        wait_valid("t5", 20);
        chk_res("t5 restart", 0, 30, 0);
        tick();
        res_ready = 1'b0;
        pulse(4'b0001, 4'b0000);
        gap(10);
        pulse(4'b0001, 4'b0001);
        gap(7);
        pulse(4'b0000, 4'b0001);
        gap(10);
        wait_valid("t5 both", 20);
        chk_res("t5 both", 0, 12, 0);
        res_ready = 1'b1;
        tick();
        check("t5 next valid", 32'(res_valid), 32'd1);
        chk_res("t5 next", 0, 9, 0);
        tick();
        check("t5 overrun", 32'(overrun), 32'd0);

        // reset mid-measurement with start held through release
        pulse(4'b1000, 4'b0000);
        gap(5);
        rst_n      = 1'b0;
        t_start[1] = 1'b1;
        gap(3);
        chk_reset("t6 in reset");
        rst_n = 1'b1;
        cnt   = 0;
        for (int i = 0; i < TO + 40; i++) begin
            tick();
            if (res_valid) cnt++;
            if (i == 100) t_start[1] = 1'b0;
        end
        check("t6 no result", 32'(cnt), 32'd0);
        chk_reset("t6 after");

        // random traffic against the model
        do_reset();
        for (int ch = 0; ch < N; ch++) begin
            st_lvl[ch] = 1'b0;
            en_lvl[ch] = 1'b0;
            st_cnt[ch] = 10;
            en_cnt[ch] = 10;
            armed[ch]  = 1'b0;
            s_cyc[ch]  = 0;
        end
        cyc       = 0;
        res_ready = 1'b1;
        mon_en    = 1'b1;
        rand_phase(5000, 1'b1);
        rand_phase(TO + 60, 1'b0);
        gap(10);
        mon_en = 1'b0;
        check("rand leftover", 32'(exp_q.size()), 32'd0);
        check("rand overrun", 32'(overrun), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
